// File: rtl/display_pkg.sv
// display_pkg: converter states, active-low 7-segment codes and the digit decoder.
package display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [9:0][7:0] SEG_TAB = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    return n > 4'd9 ? BLANK : SEG_TAB[n];
  endfunction
endpackage

// File: rtl/count_display_if.sv
// count_display_if: timer count in, display drive and latched BCD result out.
interface count_display_if #(parameter int DIGITS = 8);
  logic [31:0] count;
  logic display_en;
  logic [7:0] seg;
  logic [DIGITS-1:0] digit_en;
  logic [4*DIGITS-1:0] bcd;
  logic overflow;
  modport master(output count, display_en, input seg, digit_en, bcd, overflow);
  modport slave(input count, display_en, output seg, digit_en, bcd, overflow);
endinterface

// File: rtl/count_display_bin2bcd_seq.sv
// bin2bcd_seq: free-running 34-cycle double-dabble converter, 32-bit binary to 10 BCD digits.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] bin,
  output logic [39:0] bcd,
  output logic        done
);
  conv_state_t state;
  logic [31:0] sr;
  logic [4:0] cnt;
  logic [39:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 10; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      sr <= '0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          sr <= bin;
          bcd <= '0;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, sr} <= {adj[38:0], sr, 1'b0};
          cnt <= cnt + 5'd1;
          state <= cnt == 5'd31 ? DONE : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign done = state == DONE;
endmodule

// File: rtl/count_display.sv
// count_display: latches converted count with overflow saturation and scans it onto a
// multiplexed active-low 7-segment display with optional leading-zero blanking.
module count_display
  import display_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_ZEROS = 1
) (
  input logic HCLK,
  input logic HRESETn,
  count_display_if.slave bus
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [39:0] acc;
  logic done;
  logic [39:0] hi;
  logic [RW-1:0] refresh;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic blank;
  bin2bcd_seq u_conv (.HCLK(HCLK), .HRESETn(HRESETn), .bin(bus.count), .bcd(acc), .done(done));
  assign hi = acc >> (4*DIGITS);
  assign nib = bus.bcd[4*idx +: 4];
  // a digit blanks only when it and every more significant digit are zero
  assign blank = BLANK_ZEROS != 0 && idx != '0 && !bus.overflow && (bus.bcd >> (4*idx)) == '0;
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      bus.bcd <= '0;
      bus.overflow <= 1'b0;
      refresh <= '0;
      idx <= '0;
      bus.seg <= BLANK;
      bus.digit_en <= '1;
    end else begin
      if (done) begin
        bus.overflow <= hi != '0;
        bus.bcd <= hi != '0 ? {DIGITS{4'h9}} : acc[4*DIGITS-1:0];
      end
      refresh <= refresh == RW'(REFRESH_DIV-1) ? '0 : refresh + 1'b1;
      if (refresh == RW'(REFRESH_DIV-1))
        idx <= idx == IW'(DIGITS-1) ? '0 : idx + 1'b1;
      bus.seg <= bus.display_en && !blank ? seg_decode(nib) : BLANK;
      bus.digit_en <= bus.display_en ? ~(DIGITS'(1) << idx) : '1;
    end
  end
endmodule
